mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, number of 32-bit memory words; legal word addresses are 0..DEPTH-1.
REQ-002 SHALL have parameter DATA_W, default 32, data width of every data port.
REQ-003 SHALL have the ports below, one per line, as name, direction, width, meaning.
REQ-004 clock  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 reqA / reqB  input  1  request from requester A (CPU load/store) / B (DMA/debug).
REQ-007 weA / weB  input  1  request type: 1 = write, 0 = read.
REQ-008 addrA / addrB  input  32  word address.
REQ-009 wdataA / wdataB  input  DATA_W  write data.
REQ-010 ackA / ackB  output  1  one-cycle completion pulse.
REQ-011 errA / errB  output  1  out-of-range flag; valid only while the matching ack is high.
REQ-012 rdata  output  DATA_W  read result; valid while ackA or ackB is high.
REQ-013 memAddress  output  32  address to the data memory.
REQ-014 memWriteData  output  DATA_W  write data to the data memory.
REQ-015 memWrite / memRead  output  1  memory strobes; the memory samples them on the rising edge.
REQ-016 memReadData  input  DATA_W  memory read data; registered, valid the cycle after memRead.

Function
REQ-017 SHALL implement a three-state FSM: IDLE, ISSUE, RESP.
REQ-018 IDLE, no request: SHALL stay in IDLE.
REQ-019 IDLE, reqA or reqB high: SHALL latch the winner's we, addr and wdata plus a winner ID, then go to ISSUE.
REQ-020 Arbitration SHALL be round-robin: a lone requester wins; on a tie, the requester not granted last wins.
REQ-021 The lastGrant register SHALL update when ISSUE is entered.
REQ-022 In ISSUE, with the latched address < DEPTH: SHALL drive memAddress and memWriteData from the latched values.
REQ-023 In ISSUE, with the latched address < DEPTH: SHALL assert exactly one of memWrite (we=1) or memRead (we=0) for exactly one cycle.
REQ-024 In ISSUE, with the latched address >= DEPTH: memWrite and memRead SHALL stay 0 and the error SHALL be flagged.
REQ-025 ISSUE SHALL always go to RESP.
REQ-026 In RESP: SHALL pulse the winner's ack for one cycle, then return to IDLE.
REQ-027 In RESP, rdata SHALL equal memReadData for a valid read and 0 for a write or an error.
REQ-028 In RESP, err SHALL be 1 only for an out-of-range access.
REQ-029 Latency: req first seen high in IDLE at edge k -> mem strobe during cycle k+1 -> ack during cycle k+2.
REQ-030 Requesters SHALL hold req, we, addr and wdata stable until their ack; inputs change in ISSUE/RESP is ignored (latched copy used).
REQ-031 A req still high in the IDLE cycle after its ack SHALL be treated as a new request; back-to-back throughput is one access per 3 cycles.
REQ-032 The loser's req SHALL stay pending and SHALL win the next IDLE arbitration (no starvation).
REQ-033 memWrite, memRead, ackA, ackB, errA and errB SHALL be registered outputs, glitch-free.
REQ-034 memWrite and memRead SHALL never both be high.
REQ-035 ackA and ackB SHALL never both be high.

Reset
REQ-036 reset low SHALL force, immediately and asynchronously: state = IDLE.
REQ-037 reset low SHALL force all outputs to 0, including rdata and memAddress.
REQ-038 reset low SHALL set lastGrant = B, so A wins the first tie.
REQ-039 Reset during ISSUE or RESP SHALL abort the transfer with no ack; a memory write in progress in that cycle is not guaranteed.
REQ-040 After reset rises, the first arbitration SHALL occur at the first rising edge.

Configuration
REQ-041 Macro ARB_FIXED_PRIORITY_EN defined: A SHALL always win ties; lastGrant unused; B may starve.
REQ-042 Macro ARB_FIXED_PRIORITY_EN undefined: the round-robin rule of REQ-020 SHALL apply.

Verification
REQ-043 A write then read: reqA weA=1 addrA=5 wdataA=0xDEADBEEF, then a read of addr 5 -> memWrite for one cycle, ackA two cycles after each req, second rdata=0xDEADBEEF.
REQ-044 Tie: reqA and reqB held high continuously -> grants alternate A,B,A,B (default build); ARB_FIXED_PRIORITY_EN build -> A,A,A.
REQ-045 Out of range: reqB read addrB=1024 -> no memRead/memWrite pulse, ackB=1, errB=1, rdata=0.
REQ-046 Late requester: reqB rises during A's ISSUE -> B serviced right after A's RESP; ackB 3 cycles after ackA.
REQ-047 Reset mid-operation: reset low during RESP of an A read -> ackA=0, all outputs 0 at once; A serviced normally after release.
REQ-048 Protocol check every cycle -> memWrite&memRead never both high; ackA&ackB never both high; each ack exactly one cycle wide.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port word memory (IDLE -> ISSUE -> RESP).
// Define ARB_FIXED_PRIORITY_EN to make requester A win every tie; B may then starve.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              reqA,
  input  logic              reqB,
  input  logic              weA,
  input  logic              weB,
  input  logic [31:0]       addrA,
  input  logic [31:0]       addrB,
  input  logic [DATA_W-1:0] wdataA,
  input  logic [DATA_W-1:0] wdataB,
  output logic              ackA,
  output logic              ackB,
  output logic              errA,
  output logic              errB,
  output logic [DATA_W-1:0] rdata,
  output logic [31:0]       memAddress,
  output logic [DATA_W-1:0] memWriteData,
  output logic              memWrite,
  output logic              memRead,
  input  logic [DATA_W-1:0] memReadData
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
  typedef enum logic {GRANT_A, GRANT_B} grant_e;

  localparam logic [32:0] DEPTH_L = 33'(DEPTH);

  state_e              state_q, state_d;
  grant_e              owner_q, owner_d;
  logic                we_q, we_d;
  logic [31:0]         addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ok_q, ok_d;
  logic                mem_write_q, mem_write_d;
  logic                mem_read_q, mem_read_d;
  logic                ack_a_q, ack_a_d;
  logic                ack_b_q, ack_b_d;
  logic                err_a_q, err_a_d;
  logic                err_b_q, err_b_d;
`ifndef ARB_FIXED_PRIORITY_EN
  grant_e              last_grant_q, last_grant_d;
`endif

  grant_e              winner;
  logic                sel_we;
  logic [31:0]         sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_in_range;

  // NOTE: every variable assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    winner = GRANT_A;
    if (reqA && reqB) begin
`ifdef ARB_FIXED_PRIORITY_EN
      winner = GRANT_A;
`else
      winner = (last_grant_q == GRANT_B) ? GRANT_A : GRANT_B;
`endif
    end else if (reqB) begin
      winner = GRANT_B;
    end
  end

  assign sel_we       = (winner == GRANT_A) ? weA    : weB;
  assign sel_addr     = (winner == GRANT_A) ? addrA  : addrB;
  assign sel_wdata    = (winner == GRANT_A) ? wdataA : wdataB;
  assign sel_in_range = ({1'b0, sel_addr} < DEPTH_L);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ok_d        = ok_q;
    mem_write_d = 1'b0;
    mem_read_d  = 1'b0;
    ack_a_d     = 1'b0;
    ack_b_d     = 1'b0;
    err_a_d     = 1'b0;
    err_b_d     = 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (reqA || reqB) begin
          state_d     = ISSUE;
          owner_d     = winner;
          we_d        = sel_we;
          addr_d      = sel_addr;
          wdata_d     = sel_wdata;
          ok_d        = sel_in_range;
          // Strobes are launched from flops on the same edge that enters ISSUE.
          mem_write_d = sel_in_range & sel_we;
          mem_read_d  = sel_in_range & ~sel_we;
`ifndef ARB_FIXED_PRIORITY_EN
          last_grant_d = winner;
`endif
        end
      end
      ISSUE: begin
        state_d = RESP;
        ack_a_d = (owner_q == GRANT_A);
        ack_b_d = (owner_q == GRANT_B);
        err_a_d = (owner_q == GRANT_A) & ~ok_q;
        err_b_d = (owner_q == GRANT_B) & ~ok_q;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= GRANT_A;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ok_q         <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      err_a_q      <= 1'b0;
      err_b_q      <= 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
      last_grant_q <= GRANT_B;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      ok_q         <= ok_d;
      mem_write_q  <= mem_write_d;
      mem_read_q   <= mem_read_d;
      ack_a_q      <= ack_a_d;
      ack_b_q      <= ack_b_d;
      err_a_q      <= err_a_d;
      err_b_q      <= err_b_d;
`ifndef ARB_FIXED_PRIORITY_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign memWrite     = mem_write_q;
  assign memRead      = mem_read_q;
  assign ackA         = ack_a_q;
  assign ackB         = ack_b_q;
  assign errA         = err_a_q;
  assign errB         = err_b_q;
  assign memAddress   = (state_q == ISSUE && ok_q) ? addr_q  : '0;
  assign memWriteData = (state_q == ISSUE && ok_q) ? wdata_q : '0;
  // Read data comes straight from the registered memory output during RESP.
  assign rdata        = (state_q == RESP && ok_q && !we_q) ? memReadData : '0;

  a_strobe_excl : assert property (@(posedge clock) disable iff (!reset) !(memWrite && memRead));
  a_ack_excl    : assert property (@(posedge clock) disable iff (!reset) !(ackA && ackB));

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: per-requester drivers, a registered memory model,
// and a monitor that pops expected responses whenever an ack or memory strobe appears.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int DEPTH  = 1024;
  localparam int DATA_W = 32;
  localparam int AW     = $clog2(DEPTH);

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              reqA, reqB, weA, weB;
  logic [31:0]       addrA, addrB;
  logic [DATA_W-1:0] wdataA, wdataB;
  logic              ackA, ackB, errA, errB;
  logic [DATA_W-1:0] rdata;
  logic [31:0]       memAddress;
  logic [DATA_W-1:0] memWriteData;
  logic              memWrite, memRead;
  logic [DATA_W-1:0] memReadData;

  always #5 clock = ~clock;

  mem_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset),
    .reqA(reqA), .reqB(reqB), .weA(weA), .weB(weB),
    .addrA(addrA), .addrB(addrB), .wdataA(wdataA), .wdataB(wdataB),
    .ackA(ackA), .ackB(ackB), .errA(errA), .errB(errB), .rdata(rdata),
    .memAddress(memAddress), .memWriteData(memWriteData),
    .memWrite(memWrite), .memRead(memRead), .memReadData(memReadData)
  );

  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] data; } txn_t;
  typedef struct { bit port_b; bit err; logic [31:0] rdata; int lat; } exp_t;
  typedef struct { bit we; logic [31:0] addr; logic [31:0] data; } mexp_t;

  txn_t  qa[$], qb[$];
  exp_t  exp_q[$];
  mexp_t mem_q[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit busy_a = 0, busy_b = 0, ack_seen_a = 0, ack_seen_b = 0, prev_ack_a = 0, prev_ack_b = 0;
  int iss_a = 0, iss_b = 0, last_ack_a = 0, last_ack_b = 0;

  logic [DATA_W-1:0] mem [DEPTH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic txn_t mk(input logic we, input logic [31:0] addr, input logic [31:0] data);
    txn_t t;
    t.we = we; t.addr = addr; t.data = data;
    return t;
  endfunction

  task automatic expect_ack(input bit port_b, input bit err, input logic [31:0] rd, input int lat);
    exp_t e;
    e.port_b = port_b; e.err = err; e.rdata = rd; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic expect_mem(input bit we, input logic [31:0] addr, input logic [31:0] data);
    mexp_t m;
    m.we = we; m.addr = addr; m.data = data;
    mem_q.push_back(m);
  endtask

  // Registered single-port memory: samples strobes on the rising edge.
  always @(posedge clock) begin
    if (memWrite && memAddress < DEPTH) mem[memAddress[AW-1:0]] <= memWriteData;
    if (memRead && memAddress < DEPTH)  memReadData <= mem[memAddress[AW-1:0]];
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Requester drivers: keep req high until ack, then load the next queued item or drop req.
  initial begin
    txn_t t;
    reqA = 0; reqB = 0; weA = 0; weB = 0; addrA = 0; addrB = 0; wdataA = 0; wdataB = 0;
    forever begin
      @(posedge clock);
      #1;
      if (!reset) begin
        reqA = 0; reqB = 0; busy_a = 0; busy_b = 0;
      end else begin
        if (busy_a && ack_seen_a) busy_a = 0;
        if (!busy_a && qa.size() > 0) begin
          t = qa.pop_front();
          reqA = 1; weA = t.we; addrA = t.addr; wdataA = t.data; busy_a = 1; iss_a = cyc;
        end else if (!busy_a) reqA = 0;
        if (busy_b && ack_seen_b) busy_b = 0;
        if (!busy_b && qb.size() > 0) begin
          t = qb.pop_front();
          reqB = 1; weB = t.we; addrB = t.addr; wdataB = t.data; busy_b = 1; iss_b = cyc;
        end else if (!busy_b) reqB = 0;
      end
    end
  end

  // Monitor: protocol checks every cycle, scoreboard pops on strobes and acks.
  initial begin
    exp_t  e;
    mexp_t m;
    forever begin
      @(negedge clock);
      if (!reset) begin
        ack_seen_a = 0; ack_seen_b = 0; prev_ack_a = 0; prev_ack_b = 0;
      end else begin
        check("strobe_exclusive", memWrite & memRead, 0);
        check("ack_exclusive", ackA & ackB, 0);
        if (ackA) check("ackA_width", prev_ack_a, 0);
        if (ackB) check("ackB_width", prev_ack_b, 0);
        if (memWrite || memRead) begin
          if (mem_q.size() == 0) check("unexpected_strobe", {memWrite, memRead}, 0);
          else begin
            m = mem_q.pop_front();
            check("strobe_type", memWrite, m.we);
            check("mem_addr", memAddress, m.addr);
            if (m.we) check("mem_wdata", memWriteData, m.data);
          end
        end
        if (ackA || ackB) begin
          if (ackA) last_ack_a = cyc;
          if (ackB) last_ack_b = cyc;
          if (exp_q.size() == 0) check("unexpected_ack", {ackA, ackB}, 0);
          else begin
            e = exp_q.pop_front();
            check("ack_port", ackB, e.port_b);
            check("err", ackB ? errB : errA, e.err);
            check("rdata", rdata, e.rdata);
            check("latency", ackB ? cyc - iss_b : cyc - iss_a, e.lat);
          end
        end
        ack_seen_a = ackA; ack_seen_b = ackB;
        prev_ack_a = ackA; prev_ack_b = ackB;
      end
    end
  end

  task automatic drain();
    int n = 0;
    while ((qa.size() > 0 || qb.size() > 0 || busy_a || busy_b || exp_q.size() > 0) && n < 200) begin
      @(posedge clock);
      n++;
    end
    check("drain_timeout", (n >= 200) ? 1 : 0, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ackA"}, ackA, 0);
    check({tag, "_ackB"}, ackB, 0);
    check({tag, "_errA"}, errA, 0);
    check({tag, "_errB"}, errB, 0);
    check({tag, "_memWrite"}, memWrite, 0);
    check({tag, "_memRead"}, memRead, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_memAddress"}, memAddress, 0);
    check({tag, "_memWriteData"}, memWriteData, 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clock);
    #1 check_all_zero("reset");
    @(negedge clock) reset = 1;

    // Tie with both requesters busy; A wins the first tie after reset.
    qa.push_back(mk(1, 10, 32'hA1)); qa.push_back(mk(1, 11, 32'hA2)); qa.push_back(mk(1, 12, 32'hA3));
    qb.push_back(mk(1, 20, 32'hB1)); qb.push_back(mk(1, 21, 32'hB2));
`ifdef ARB_FIXED_PRIORITY_EN
    expect_ack(0, 0, 0, 2); expect_ack(0, 0, 0, 2); expect_ack(0, 0, 0, 2);
    expect_ack(1, 0, 0, 11); expect_ack(1, 0, 0, 2);
    expect_mem(1, 10, 32'hA1); expect_mem(1, 11, 32'hA2); expect_mem(1, 12, 32'hA3);
    expect_mem(1, 20, 32'hB1); expect_mem(1, 21, 32'hB2);
`else
    expect_ack(0, 0, 0, 2); expect_ack(1, 0, 0, 5); expect_ack(0, 0, 0, 5);
    expect_ack(1, 0, 0, 5); expect_ack(0, 0, 0, 5);
    expect_mem(1, 10, 32'hA1); expect_mem(1, 20, 32'hB1); expect_mem(1, 11, 32'hA2);
    expect_mem(1, 21, 32'hB2); expect_mem(1, 12, 32'hA3);
`endif
    drain();

    // Write then read back on A, back to back.
    qa.push_back(mk(1, 5, 32'hDEADBEEF)); qa.push_back(mk(0, 5, 0));
    expect_ack(0, 0, 0, 2); expect_ack(0, 0, 32'hDEADBEEF, 2);
    expect_mem(1, 5, 32'hDEADBEEF); expect_mem(0, 5, 0);
    drain();

    // Range boundaries on B, then read the last legal word from A.
    qb.push_back(mk(0, 1024, 0)); qb.push_back(mk(1, 1023, 32'h12345678));
    qb.push_back(mk(1, 32'hFFFF_FFFF, 32'h55));
    expect_ack(1, 1, 0, 2); expect_ack(1, 0, 0, 2); expect_ack(1, 1, 0, 2);
    expect_mem(1, 1023, 32'h12345678);
    drain();
    qa.push_back(mk(0, 1023, 0));
    expect_ack(0, 0, 32'h12345678, 2);
    expect_mem(0, 1023, 0);
    drain();

    // Late requester: B arrives during A's ISSUE and is served right after A.
    qa.push_back(mk(0, 5, 0));
    expect_ack(0, 0, 32'hDEADBEEF, 2); expect_ack(1, 0, 32'h12345678, 4);
    expect_mem(0, 5, 0); expect_mem(0, 1023, 0);
    @(posedge clock);
    #2 qb.push_back(mk(0, 1023, 0));
    drain();
    check("late_ack_gap", last_ack_b - last_ack_a, 3);

    // Reset asserted during the RESP cycle of an A read aborts the ack.
    qa.push_back(mk(0, 5, 0));
    expect_mem(0, 5, 0);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!memRead && n < 20);
    check("rd_strobe_timeout", (n >= 20) ? 1 : 0, 0);
    @(posedge clock);
    #1 reset = 0;
    #1 check_all_zero("midreset");
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1;
    qa.push_back(mk(0, 5, 0));
    expect_ack(0, 0, 32'hDEADBEEF, 2);
    expect_mem(0, 5, 0);
    drain();

    check("leftover_acks", exp_q.size(), 0);
    check("leftover_strobes", mem_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
